// File: rtl/frv_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : frv_mem_responder
// Purpose  : Single-port memory slave for a core imem/dmem port. Accepts
//            req/gnt requests, holds a word-addressed RAM, and returns
//            in-order responses through a small recv/ack queue.
// Revision : 1.0 - initial release
// ============================================================================
module frv_mem_responder #(
  parameter logic [31:0] MEM_BASE    = 32'h0000_0000,
  parameter int          MEM_WORDS   = 1024,
  parameter int          OUTSTANDING = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_wen,
  input  logic [3:0]  mem_strb,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr,
  output logic        mem_gnt,
  output logic        mem_recv,
  input  logic        mem_ack,
  output logic        mem_error,
  output logic [31:0] mem_rdata,
  input  logic        stall_req,
  output logic [31:0] txn_count
);

  localparam int c_aw = $clog2(MEM_WORDS);
  localparam int c_pw = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int c_cw = $clog2(OUTSTANDING + 1);
  localparam logic [c_cw-1:0] c_full = c_cw'(OUTSTANDING);
  localparam logic [c_pw-1:0] c_last = c_pw'(OUTSTANDING - 1);

  // RAM contents survive reset; benches preload them directly.
  logic [31:0]     ram_q [MEM_WORDS];

  logic [c_cw-1:0] count_q, count_d;
  logic [c_pw-1:0] wptr_q, wptr_d;
  logic [c_pw-1:0] rptr_q, rptr_d;
  logic            q_err_q  [OUTSTANDING];
  logic            q_err_d  [OUTSTANDING];
  logic [31:0]     q_data_q [OUTSTANDING];
  logic [31:0]     q_data_d [OUTSTANDING];
  logic [31:0]     txn_q, txn_d;

  logic            w_gnt;
  logic            w_accept;
  logic            w_pop;
  logic            w_borrow;
  logic [31:0]     w_off;
  logic [c_aw-1:0] w_idx;
  logic            w_err;
  logic [31:0]     w_rword;

  function automatic logic [c_pw-1:0] ptr_inc(input logic [c_pw-1:0] p);
    return (p == c_last) ? '0 : p + 1'b1;
  endfunction

  // Handshake decode and address check. The borrow out of (addr - base)
  // flags addresses below the window; any offset bit above the RAM span
  // flags addresses at or beyond its end.
  always_comb begin
    w_gnt              = !reset && !stall_req && (count_q < c_full);
    w_accept           = mem_req && w_gnt;
    w_pop              = (count_q != '0) && mem_ack;
    {w_borrow, w_off}  = {1'b0, mem_addr} - {1'b0, MEM_BASE};
    w_idx              = w_off[c_aw+1:2];
    w_err              = (w_off[1:0] != 2'b00) || w_borrow ||
                         ((w_off >> (c_aw + 2)) != 32'd0);
    w_rword            = ram_q[w_idx];
  end

  // Next-state for the response FIFO and the completion counter.
  always_comb begin
    count_d  = count_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    q_err_d  = q_err_q;
    q_data_d = q_data_q;
    txn_d    = txn_q;
    if (w_accept) begin
      q_err_d[wptr_q]  = w_err;
      q_data_d[wptr_q] = (w_err || mem_wen) ? 32'h0 : w_rword;
      wptr_d           = ptr_inc(wptr_q);
    end
    if (w_pop) begin
      rptr_d = ptr_inc(rptr_q);
      txn_d  = txn_q + 32'd1;
    end
    case ({w_accept, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state: pointers, occupancy and counter clear on reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      txn_q   <= '0;
    end else begin
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      txn_q   <= txn_d;
    end
  end

  // FIFO payload storage; stale entries are masked by the occupancy count.
  always_ff @(posedge clock) begin
    q_err_q  <= q_err_d;
    q_data_q <= q_data_d;
  end

  // Byte-lane RAM write; the read above sees the pre-write word.
  always_ff @(posedge clock) begin
    if (w_accept && mem_wen && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_strb[i]) begin
          ram_q[w_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
      end
    end
  end

  assign mem_gnt   = w_gnt;
  assign mem_recv  = (count_q != '0);
  assign mem_error = mem_recv ? q_err_q[rptr_q]  : 1'b0;
  assign mem_rdata = mem_recv ? q_data_q[rptr_q] : 32'h0;
  assign txn_count = txn_q;

endmodule
`default_nettype wire

// File: doc/frv_mem_responder.md
Name: frv_mem_responder

Overview:
Single-port memory slave that terminates one core memory interface (instruction or data) with the req/gnt request handshake and recv/ack response handshake. Sits directly downstream of the core's imem_*/dmem_* ports. Used in simulation benches and bounded formal runs in place of unconstrained inputs. Holds a word-addressed RAM, queues up to OUTSTANDING in-order responses, flags bus errors, and offers a backpressure input to exercise grant stalls.

Parameters:
MEM_BASE, 32'h0000_0000, byte address of RAM word 0; must be 4-byte aligned.
MEM_WORDS, 1024, RAM depth in 32-bit words; must be a power of two, at least 2.
OUTSTANDING, 2, response queue depth; must be at least 1.

Ports:
clock  input  1  global clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
mem_req  input  1  core starts request
mem_wen  input  1  1 = write, 0 = read
mem_strb  input  4  byte write strobe, bit i selects wdata[8i+7:8i]
mem_wdata  input  32  write data
mem_addr  input  32  byte address
mem_gnt  output  1  request accepted this cycle (combinational)
mem_recv  output  1  response valid
mem_ack  input  1  core accepts response
mem_error  output  1  response carries bus error; valid while mem_recv
mem_rdata  output  32  read data; valid while mem_recv
stall_req  input  1  bench backpressure; forces mem_gnt low
txn_count  output  32  count of completed responses (recv && ack)

Behaviour:
- Accept: mem_gnt = !reset && !stall_req && (count < OUTSTANDING). A request is accepted when mem_req && mem_gnt. Count is the number of queued responses before this cycle's pop, so a full queue never grants, even if a pop happens in the same cycle.
- Address check at accept:
  - err = (mem_addr[1:0] != 0) || mem_addr < MEM_BASE || mem_addr >= MEM_BASE + 4*MEM_WORDS.
  - Index = (mem_addr - MEM_BASE) >> 2, truncated to log2(MEM_WORDS) bits.
- Read at accept: the RAM word is sampled before any write in the same cycle and pushed as {err=0, rdata=word}.
- Write at accept (mem_wen=1, no error):
  - Only bytes with strb set are updated; strb=0 is legal and changes nothing.
  - Pushed entry is {err=0, rdata=32'h0}.
- Error at accept: no RAM update; entry is {err=1, rdata=32'h0}.
- Queue:
  - In-order FIFO of {error, rdata}, depth OUTSTANDING, with wrapping read/write pointers.
  - Push on accept, pop when mem_recv && mem_ack.
  - Push and pop in the same cycle leave count unchanged and are legal.
  - Count range is 0..OUTSTANDING; no overflow or underflow is possible.
- Response:
  - mem_recv = (count != 0), registered from state.
  - mem_error and mem_rdata drive the head entry, and 0 when empty.
  - Minimum latency: accept in cycle N gives mem_recv=1 in cycle N+1.
  - The head holds stable until acked.
  - mem_ack while mem_recv=0 is ignored.
- txn_count increments by 1 per pop and wraps at 2^32.
- Reset:
  - Outputs after the reset edge: mem_recv=0, mem_error=0, mem_rdata=0, txn_count=0, mem_gnt=0 while reset is high.
  - Queue pointers and count clear.
  - Pending responses are discarded, including mid-transaction.
  - RAM contents are not reset; benches preload RAM through hierarchical access or $readmemh in the bench.
- stall_req affects only mem_gnt; queued responses still drain.
- mem_req held without grant creates no state; the request is re-evaluated each cycle.

Test Plan:
1. Reset, then write addr 0x10, wdata 0xDEADBEEF, strb 4'hF, ack held 1 -> gnt same cycle, recv next cycle with error=0, rdata=0, txn_count=1. Then read 0x10 -> rdata=0xDEADBEEF.
2. Partial write strb 4'b0010, wdata 0x0000AB00 over 0xDEADBEEF at 0x10 -> subsequent read returns 0xDEADABEF.
3. Back-to-back reads with ack=0, OUTSTANDING=2 -> two grants, third request sees gnt=0. Ack one -> gnt=1 the cycle after the pop. Responses return in order.
4. Read at 0x13 (misaligned) and at MEM_BASE+4*MEM_WORDS (out of range) -> error=1, rdata=0. Write to 0x1000 (out of range) leaves RAM unchanged.
5. stall_req=1 with req held for 5 cycles -> gnt=0 throughout, queued responses still drain. Release stall -> gnt=1 the same cycle.
6. Two responses queued, assert reset for 1 cycle -> recv=0 and txn_count=0 after the edge. Earlier-written RAM data is still readable.
